// File: rtl/region_pkg.sv
// Shared definitions for the glove region detector and the overlay stage.
//   NUM_REGIONS / CNT_W : band count and per-band pixel counter width
//   REG_*               : band index for each colour flag
//   state_t             : detector frame FSM states
//   sat_inc             : saturating increment for the band counters
package region_pkg;

  localparam int unsigned NUM_REGIONS = 4;
  localparam int unsigned CNT_W       = 17;

  localparam int unsigned REG_RED    = 0;
  localparam int unsigned REG_GREEN  = 1;
  localparam int unsigned REG_BLUE   = 2;
  localparam int unsigned REG_YELLOW = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_EVAL   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

endpackage

// File: rtl/region_hyst.sv
// Per-band hysteresis: saturating persistence counter plus flag register.
//   clk, reset : pixel clock, synchronous active-high reset
//   step       : one-cycle strobe, apply this frame's result
//   hit        : band count reached threshold this frame
//   en         : detection enable; when low, the step clears counter and flag
//   flag       : band occupied (registered)
module region_hyst #(
  parameter int unsigned PERSIST = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  logic hit,
  input  logic en,
  output logic flag
);

  localparam int unsigned PW = $clog2(PERSIST + 1);
  localparam logic [PW-1:0] P_MAX = PW'(PERSIST);

  logic [PW-1:0] p;
  logic [PW-1:0] p_next;

  always_comb begin
    p_next = p;
    if (!en)
      p_next = '0;
    else if (hit)
      p_next = (p == P_MAX) ? p : p + PW'(1);
    else
      p_next = (p == '0) ? p : p - PW'(1);
  end

  // The flag is decided from p_next so it lands in the same edge as the
  // counter update; this keeps flags visible two cycles after frame_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      p    <= '0;
      flag <= 1'b0;
    end else if (step) begin
      p <= p_next;
      if (p_next == P_MAX)
        flag <= 1'b1;
      else if (p_next == '0)
        flag <= 1'b0;
    end
  end

endmodule

// File: rtl/glove_region_detector.sv
// Glove region detector: classifies active pixels by a Cb/Cr window, counts
// glove pixels in four vertical bands per frame, thresholds the counts and
// applies multi-frame hysteresis to drive the region flags for the overlay.
//   clk, reset          : pixel clock, synchronous active-high reset
//   en_regions          : detection enable
//   frame_start         : one-cycle pulse at start of each frame
//   pix_valid           : qualifies x_pos, y_pos, Cb_in, Cr_in
//   x_pos, y_pos        : pixel coordinates
//   Cb_in, Cr_in        : chroma samples
//   red/green/blue/yellow_flag : bands 0..3 occupied
//   flags_valid         : one-cycle pulse when the flags are updated
module glove_region_detector
  import region_pkg::*;
#(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned REGION_W     = 160,
  parameter logic [7:0]  CB_MIN       = 8'd77,
  parameter logic [7:0]  CB_MAX       = 8'd127,
  parameter logic [7:0]  CR_MIN       = 8'd133,
  parameter logic [7:0]  CR_MAX       = 8'd173,
  parameter int unsigned COUNT_THRESH = 2000,
  parameter int unsigned PERSIST      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en_regions,
  input  logic       frame_start,
  input  logic       pix_valid,
  input  logic [9:0] x_pos,
  input  logic [9:0] y_pos,
  input  logic [7:0] Cb_in,
  input  logic [7:0] Cr_in,
  output logic       red_flag,
  output logic       green_flag,
  output logic       blue_flag,
  output logic       yellow_flag,
  output logic       flags_valid
);

  state_t state;

  logic [CNT_W-1:0]       cnt [NUM_REGIONS];
  logic [NUM_REGIONS-1:0] hit;
  logic [NUM_REGIONS-1:0] flag;

  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        in_range;
  logic        in_window;
  logic        glove;
  logic [1:0]  band;

  always_comb begin
    x_ext     = {1'b0, x_pos};
    y_ext     = {1'b0, y_pos};
    in_range  = (x_ext < 11'(H_ACTIVE)) && (y_ext < 11'(V_ACTIVE));
    in_window = (Cb_in >= CB_MIN) && (Cb_in <= CB_MAX) &&
                (Cr_in >= CR_MIN) && (Cr_in <= CR_MAX);
    glove     = pix_valid && en_regions && in_range && in_window;

    if (x_ext < 11'(REGION_W))
      band = 2'd0;
    else if (x_ext < 11'(2 * REGION_W))
      band = 2'd1;
    else if (x_ext < 11'(3 * REGION_W))
      band = 2'd2;
    else
      band = 2'd3;
  end

  always_comb begin
    hit = '0;
    for (int unsigned k = 0; k < NUM_REGIONS; k++)
      hit[k] = (cnt[k] >= CNT_W'(COUNT_THRESH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      flags_valid <= 1'b0;
      for (int unsigned k = 0; k < NUM_REGIONS; k++)
        cnt[k] <= '0;
    end else begin
      flags_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (frame_start)
            state <= ST_ACCUM;
        end
        ST_ACCUM: begin
          if (glove)
            cnt[band] <= sat_inc(cnt[band]);
          if (frame_start)
            state <= ST_EVAL;
        end
        // flags_valid is raised here so it coincides with the flag update
        // made by the hysteresis registers on the same edge.
        ST_EVAL: begin
          flags_valid <= 1'b1;
          state       <= ST_UPDATE;
        end
        ST_UPDATE: begin
          for (int unsigned k = 0; k < NUM_REGIONS; k++)
            cnt[k] <= '0;
          state <= ST_ACCUM;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_hyst
    region_hyst #(
      .PERSIST(PERSIST)
    ) u_hyst (
      .clk  (clk),
      .reset(reset),
      .step (state == ST_EVAL),
      .hit  (hit[g]),
      .en   (en_regions),
      .flag (flag[g])
    );
  end

  assign red_flag    = flag[REG_RED];
  assign green_flag  = flag[REG_GREEN];
  assign blue_flag   = flag[REG_BLUE];
  assign yellow_flag = flag[REG_YELLOW];

endmodule

// File: tb/tb_glove_region_detector.sv
module tb_glove_region_detector;

  localparam int H  = 8;
  localparam int V  = 2;
  localparam int RW = 2;
  localparam int TH = 2;
  localparam int PS = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       en_regions;
  logic       frame_start;
  logic       pix_valid;
  logic [9:0] x_pos;
  logic [9:0] y_pos;
  logic [7:0] Cb_in;
  logic [7:0] Cr_in;
  logic       red_flag, green_flag, blue_flag, yellow_flag, flags_valid;

  always #5 clk = ~clk;

  glove_region_detector #(
    .H_ACTIVE    (H),
    .V_ACTIVE    (V),
    .REGION_W    (RW),
    .COUNT_THRESH(TH),
    .PERSIST     (PS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en_regions (en_regions),
    .frame_start(frame_start),
    .pix_valid  (pix_valid),
    .x_pos      (x_pos),
    .y_pos      (y_pos),
    .Cb_in      (Cb_in),
    .Cr_in      (Cr_in),
    .red_flag   (red_flag),
    .green_flag (green_flag),
    .blue_flag  (blue_flag),
    .yellow_flag(yellow_flag),
    .flags_valid(flags_valid)
  );

  int total  = 0;
  int passed = 0;

  // Reference model: frame-level view of counts, persistence and flags.
  int       m_cnt [4];
  int       m_p   [4];
  bit [3:0] m_flags;
  bit       m_started;

  function automatic void model_reset();
    for (int k = 0; k < 4; k++) begin
      m_cnt[k] = 0;
      m_p[k]   = 0;
    end
    m_flags   = '0;
    m_started = 1'b0;
  endfunction

  function automatic void model_pixel(int x, int y, int cb, int cr, bit en);
    int b;
    if (m_started && en && x < H && y < V &&
        cb >= 77 && cb <= 127 && cr >= 133 && cr <= 173) begin
      b = x / RW;
      if (b > 3) b = 3;
      m_cnt[b]++;
    end
  endfunction

  function automatic void model_boundary(bit en);
    if (!m_started) begin
      m_started = 1'b1;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!en)                 m_p[k] = 0;
        else if (m_cnt[k] >= TH) m_p[k] = (m_p[k] + 1 > PS) ? PS : m_p[k] + 1;
        else                     m_p[k] = (m_p[k] - 1 < 0) ? 0 : m_p[k] - 1;
        if (m_p[k] == PS)     m_flags[k] = 1'b1;
        else if (m_p[k] == 0) m_flags[k] = 1'b0;
      end
    end
    for (int k = 0; k < 4; k++) m_cnt[k] = 0;
  endfunction

  function automatic logic [3:0] obs_flags();
    return {yellow_flag, blue_flag, green_flag, red_flag};
  endfunction

  // Called just after a negedge; returns just after a negedge.
  task automatic send_pixel(input int x, input int y, input int cb, input int cr);
    pix_valid = 1'b1;
    x_pos = 10'(x);
    y_pos = 10'(y);
    Cb_in = 8'(cb);
    Cr_in = 8'(cr);
    model_pixel(x, y, cb, cr, en_regions);
    @(negedge clk);
    pix_valid = 1'b0;
  endtask

  task automatic frame_boundary(input string name, input int hold);
    bit         exp_pulse;
    logic [3:0] prev_flags;
    logic [3:0] exp_flags;
    logic       exp_fv;
    exp_pulse  = m_started;
    prev_flags = m_flags;
    model_boundary(en_regions);
    exp_flags  = m_flags;
    frame_start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      frame_start = (i < hold);
      exp_fv = exp_pulse && (i == 2);
      total++;
      if (flags_valid !== exp_fv)
        $display("FAIL %s fv[c%0d]: got %b expected %b", name, i, flags_valid, exp_fv);
      else passed++;
      total++;
      if (i == 1) begin
        if (obs_flags() !== prev_flags)
          $display("FAIL %s early_flags: got %b expected %b", name, obs_flags(), prev_flags);
        else passed++;
      end else begin
        if (obs_flags() !== exp_flags)
          $display("FAIL %s flags[c%0d]: got %b expected %b", name, i, obs_flags(), exp_flags);
        else passed++;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (obs_flags() !== 4'b0000)
      $display("FAIL reset_flags: got %b expected 0000", obs_flags());
    else passed++;
    total++;
    if (flags_valid !== 1'b0)
      $display("FAIL reset_fv: got %b expected 0", flags_valid);
    else passed++;
    reset = 1'b0;
    model_reset();
    // Pixels while idle must not be counted.
    send_pixel(0, 0, 100, 150);
    send_pixel(1, 0, 100, 150);
    frame_boundary("first_fs", 1);
  endtask

  task automatic test_red_persist();
    for (int f = 0; f < 2; f++) begin
      send_pixel(0, 0, 100, 150);
      send_pixel(1, 0, 100, 150);
      send_pixel(1, 1, 100, 150);
      frame_boundary("red_set", 1);
    end
    frame_boundary("red_hold", 1);
    frame_boundary("red_clear", 1);
  endtask

  task automatic test_window_edges();
    for (int f = 0; f < 2; f++) begin
      send_pixel(7, 0, 76, 150);
      send_pixel(7, 1, 76, 150);
      send_pixel(9, 0, 100, 150);
      send_pixel(9, 1, 100, 150);
      send_pixel(6, 2, 100, 150);
      send_pixel(7, 0, 128, 150);
      send_pixel(7, 0, 100, 132);
      send_pixel(7, 0, 100, 174);
      frame_boundary("yellow_out", 1);
    end
    for (int f = 0; f < 2; f++) begin
      send_pixel(7, 0, 77, 133);
      send_pixel(6, 1, 127, 173);
      frame_boundary("yellow_in", 1);
    end
  endtask

  task automatic test_multi_band();
    for (int f = 0; f < 2; f++) begin
      send_pixel(2, 0, 90, 140);
      send_pixel(3, 1, 90, 140);
      send_pixel(4, 0, 120, 170);
      send_pixel(5, 0, 120, 170);
      frame_boundary("multi_band", 1);
    end
  endtask

  task automatic test_disable();
    en_regions = 1'b0;
    send_pixel(2, 0, 90, 140);
    send_pixel(3, 0, 90, 140);
    frame_boundary("disable", 1);
    en_regions = 1'b1;
    for (int f = 0; f < 2; f++) begin
      send_pixel(4, 0, 100, 150);
      send_pixel(5, 1, 100, 150);
      frame_boundary("reenable", 1);
    end
  endtask

  task automatic test_reset_mid();
    send_pixel(0, 0, 100, 150);
    send_pixel(1, 0, 100, 150);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    total++;
    if (obs_flags() !== 4'b0000)
      $display("FAIL midreset_flags: got %b expected 0000", obs_flags());
    else passed++;
    total++;
    if (flags_valid !== 1'b0)
      $display("FAIL midreset_fv: got %b expected 0", flags_valid);
    else passed++;
    frame_boundary("after_reset_idle", 1);
    send_pixel(0, 0, 100, 150);
    frame_boundary("after_reset_f1", 1);
    frame_boundary("after_reset_f2", 1);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      send_pixel(0, 0, 100, 150);
      send_pixel(1, 1, 100, 150);
      frame_boundary("long_fs", 3 - f);
    end
  endtask

  task automatic test_random();
    int n;
    for (int f = 0; f < 16; f++) begin
      en_regions = ($urandom_range(0, 5) != 0);
      n = $urandom_range(0, 8);
      for (int i = 0; i < n; i++)
        send_pixel($urandom_range(0, 11), $urandom_range(0, 2),
                   $urandom_range(70, 135), $urandom_range(128, 180));
      frame_boundary("random", 1);
    end
    en_regions = 1'b1;
  endtask

  initial begin
    reset       = 1'b1;
    en_regions  = 1'b1;
    frame_start = 1'b0;
    pix_valid   = 1'b0;
    x_pos       = '0;
    y_pos       = '0;
    Cb_in       = '0;
    Cr_in       = '0;
    model_reset();
    @(negedge clk);
    test_reset();
    test_red_persist();
    test_window_edges();
    test_multi_band();
    test_disable();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/glove_region_detector.md
Name: glove_region_detector

Overview:
- Producer side of the region-flag interface read by the overlay drawing stage.
- Watches the camera pixel stream and classifies each active pixel as glove or not, using a chroma window on Cb/Cr.
- Counts glove pixels in each of four vertical screen bands per frame, applies a threshold and a multi-frame hysteresis, then drives red/green/blue/yellow region flags.
- Sits between the YCbCr capture path and the overlay stage, in the camera clock domain.

Parameters:
- H_ACTIVE, 640, active pixels per line; pixels with x_pos >= H_ACTIVE are ignored.
- V_ACTIVE, 480, active lines; pixels with y_pos >= V_ACTIVE are ignored.
- REGION_W, 160, band width; band k covers k*REGION_W <= x < (k+1)*REGION_W, with k=3 extending to H_ACTIVE-1.
- CB_MIN / CB_MAX, 8'd77 / 8'd127, inclusive Cb window for a glove pixel.
- CR_MIN / CR_MAX, 8'd133 / 8'd173, inclusive Cr window for a glove pixel.
- COUNT_THRESH, 2000, a band is "hit" for a frame when its count >= COUNT_THRESH.
- PERSIST, 3, consecutive-hit depth for hysteresis (must be >= 1).

Ports:
- clk, in, 1, pixel clock.
- reset, in, 1, synchronous, active-high.
- en_regions, in, 1, detection enable.
- frame_start, in, 1, single-cycle pulse at the start of each frame (vsync edge).
- pix_valid, in, 1, qualifies x_pos/y_pos/Cb_in/Cr_in this cycle.
- x_pos, in, 10, pixel column.
- y_pos, in, 10, pixel row.
- Cb_in, in, 8, chroma blue.
- Cr_in, in, 8, chroma red.
- red_flag, out, 1, band 0 occupied.
- green_flag, out, 1, band 1 occupied.
- blue_flag, out, 1, band 2 occupied.
- yellow_flag, out, 1, band 3 occupied.
- flags_valid, out, 1, one-cycle pulse when the flags are updated.

Behaviour:
- Reset: FSM goes to IDLE; all counts, persistence counters, flags and flags_valid are 0.
- FSM states:
  - IDLE: on frame_start, go to ACCUM. No evaluation, because there is no prior frame.
  - ACCUM: on each cycle with pix_valid=1, in-range coordinates, Cb within [CB_MIN,CB_MAX] and Cr within [CR_MIN,CR_MAX], increment the band counter selected by x_pos. On frame_start, go to EVAL.
  - EVAL (1 cycle): compute hit[k] = (cnt[k] >= COUNT_THRESH). For each band, persistence p[k] increments on a hit (saturating at PERSIST) and decrements on a miss (saturating at 0).
  - UPDATE (1 cycle): for each band, flag[k] is set when p[k]==PERSIST, cleared when p[k]==0, and otherwise holds. Pulse flags_valid=1, clear all cnt[k], return to ACCUM.
- Latency: frame_start at cycle T gives EVAL at T+1; flags and flags_valid change at T+2 (registered outputs).
- Pixels presented during EVAL or UPDATE are dropped. This is legal because the source is in blanking there.
- A frame_start arriving during EVAL or UPDATE is ignored.
- Counters are 17 bits and saturate at 17'h1FFFF, so they never wrap.
- Band select uses the comparisons x < REGION_W, x < 2*REGION_W, x < 3*REGION_W, otherwise band 3. Any number of flags may be 1 at once; priority among them belongs to the consumer.
- en_regions=0:
  - Counts do not increment.
  - At the next UPDATE all p[k] and flags are forced to 0; flags_valid still pulses.
  - Re-enabling resumes normal accumulation from the next frame.
- Reset mid-frame takes priority over everything and returns the block to IDLE.

Decomposition:
- Shared package `region_pkg`:
  - constants NUM_REGIONS=4, CNT_W=17;
  - region index localparams REG_RED=0, REG_GREEN=1, REG_BLUE=2, REG_YELLOW=3 (shared with the overlay stage);
  - FSM state encoding.
- One natural sub-module, `region_hyst`: per-band saturating persistence counter plus flag register, instantiated 4 times.

Test Plan (sim params: H_ACTIVE=8, V_ACTIVE=2, REGION_W=2, COUNT_THRESH=2, PERSIST=2):
- Reset held 3 cycles, then released -> all flags 0, flags_valid 0; first frame_start produces no flags_valid.
- Two frames with 3 in-window pixels (Cb=100, Cr=150) at x=0,1 -> red_flag=0 after frame 1, red_flag=1 at T+2 after the second trailing frame_start; flags_valid pulses exactly 1 cycle each time.
- Red latched, then 1 frame with 0 glove pixels -> red stays 1; a second empty frame -> red_flag=0.
- Pixels at x=7 with Cb=76 (out of window) plus x=9 (out of range) -> cnt[3]=0 and yellow_flag stays 0; the same x=7 pixels with Cb=77 set yellow after 2 frames.
- Bands 1 and 2 both hit for 2 frames -> green_flag=1 and blue_flag=1 simultaneously.
- Flags set, en_regions=0 across one frame_start -> all flags 0 at T+2; reset asserted mid-ACCUM -> outputs 0 and the next frame_start is treated as from IDLE.
